// File: rtl/cmul_ctrl.sv
// Sequencing controller for a shared-multiplier complex product (ar+j*ai)*(br+j*bi).
// Four partial products go through one multiplier, combined into Pr and Pi.
module cmul_ctrl #(
  parameter int DW = 12
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_in_valid,
  output logic          o_in_ready,
  input  logic [DW-1:0] i_ar_in,
  input  logic [DW-1:0] i_ai_in,
  input  logic [DW-1:0] i_br_in,
  input  logic [DW-1:0] i_bi_in,
  output logic [DW-1:0] o_ar,
  output logic [DW-1:0] o_ai,
  output logic [DW-1:0] o_br,
  output logic [DW-1:0] o_bi,
  output logic          o_a_sel,
  output logic          o_b_sel,
  output logic          o_pp1_ce,
  output logic          o_pp2_ce,
  output logic          o_add,
  output logic          o_pr_ce,
  output logic          o_pi_ce,
  output logic          o_out_valid,
  input  logic          i_out_ready,
  output logic          o_busy,
  output logic [15:0]   o_op_count
);

  // state | meaning
  // IDLE  | waiting for operands, in_ready high
  // S1    | PP1 := ar*br
  // S2    | PP2 := ai*bi
  // S3    | Pr := PP1-PP2, and PP1 := ar*bi in the same cycle
  // S4    | PP2 := ai*br
  // S5    | Pi := PP1+PP2
  // DONE  | result held until out_ready
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S1   = 3'd1,
    S2   = 3'd2,
    S3   = 3'd3,
    S4   = 3'd4,
    S5   = 3'd5,
    DONE = 3'd6
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [DW-1:0] r_ar, r_ai, r_br, r_bi;
  logic [15:0]   r_op_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Operands are only captured on the IDLE handshake, so they hold through DONE.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ar <= '0;
      r_ai <= '0;
      r_br <= '0;
      r_bi <= '0;
    end else if (r_state == IDLE && i_in_valid) begin
      r_ar <= i_ar_in;
      r_ai <= i_ai_in;
      r_br <= i_br_in;
      r_bi <= i_bi_in;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)                               r_op_count <= '0;
    else if (r_state == DONE && i_out_ready) r_op_count <= r_op_count + 16'd1;
  end

  always_comb begin
    w_next      = r_state;
    o_in_ready  = 1'b0;
    o_a_sel     = 1'b0;
    o_b_sel     = 1'b0;
    o_pp1_ce    = 1'b0;
    o_pp2_ce    = 1'b0;
    o_add       = 1'b0;
    o_pr_ce     = 1'b0;
    o_pi_ce     = 1'b0;
    o_out_valid = 1'b0;
    o_busy      = 1'b1;
    case (r_state)
      IDLE: begin
        o_in_ready = 1'b1;
        o_busy     = 1'b0;
        if (i_in_valid) w_next = S1;
      end
      S1: begin
        o_pp1_ce = 1'b1;
        w_next   = S2;
      end
      S2: begin
        o_a_sel  = 1'b1;
        o_b_sel  = 1'b1;
        o_pp2_ce = 1'b1;
        w_next   = S3;
      end
      // PR samples the pre-edge PP1/PP2 while PP1 is reloaded.
      S3: begin
        o_add    = 1'b1;
        o_pr_ce  = 1'b1;
        o_b_sel  = 1'b1;
        o_pp1_ce = 1'b1;
        w_next   = S4;
      end
      S4: begin
        o_a_sel  = 1'b1;
        o_pp2_ce = 1'b1;
        w_next   = S5;
      end
      S5: begin
        o_pi_ce = 1'b1;
        w_next  = DONE;
      end
      DONE: begin
        o_out_valid = 1'b1;
        if (i_out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign o_ar       = r_ar;
  assign o_ai       = r_ai;
  assign o_br       = r_br;
  assign o_bi       = r_bi;
  assign o_op_count = r_op_count;

endmodule

// File: tb/tb_cmul_ctrl.sv
// Bench for cmul_ctrl: attaches a shared-multiplier datapath model and checks
// control sequencing, results, latency, backpressure and reset behaviour.
module tb_cmul_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] ar_in = '0, ai_in = '0, br_in = '0, bi_in = '0;
  logic [11:0] ar, ai, br, bi;
  logic        a_sel, b_sel, pp1_ce, pp2_ce, add, pr_ce, pi_ce;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        busy;
  logic [15:0] op_count;

  always #5 clk = ~clk;

  cmul_ctrl #(.DW(12)) dut (
    .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_ar_in(ar_in), .i_ai_in(ai_in), .i_br_in(br_in), .i_bi_in(bi_in),
    .o_ar(ar), .o_ai(ai), .o_br(br), .o_bi(bi),
    .o_a_sel(a_sel), .o_b_sel(b_sel), .o_pp1_ce(pp1_ce), .o_pp2_ce(pp2_ce),
    .o_add(add), .o_pr_ce(pr_ce), .o_pi_ce(pi_ce), .o_out_valid(out_valid),
    .i_out_ready(out_ready), .o_busy(busy), .o_op_count(op_count)
  );

  // Datapath model: operand muxes, one multiplier, PP1/PP2, combiner, Pr/Pi.
  logic [23:0] pp1 = '0, pp2 = '0, pr = '0, pi = '0;
  logic [11:0] mux_a, mux_b;
  assign mux_a = a_sel ? ai : ar;
  assign mux_b = b_sel ? bi : br;
  always @(posedge clk) begin
    if (pp1_ce) pp1 <= 24'(mux_a) * 24'(mux_b);
    if (pp2_ce) pp2 <= 24'(mux_a) * 24'(mux_b);
    if (pr_ce)  pr  <= add ? (pp1 - pp2) : (pp1 + pp2);
    if (pi_ce)  pi  <= add ? (pp1 - pp2) : (pp1 + pp2);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_count = '0;

  typedef struct {
    logic [23:0] pr;
    logic [23:0] pi;
  } exp_t;
  exp_t sb[$];

  logic [7:0] ctrl;
  assign ctrl = {a_sel, b_sel, pp1_ce, pp2_ce, add, pr_ce, pi_ce, out_valid};

  // Expected {a_sel,b_sel,pp1_ce,pp2_ce,add,pr_ce,pi_ce,out_valid} per phase.
  function automatic logic [7:0] ctrl_exp(input int ph);
    case (ph)
      1:       return 8'b0010_0000;
      2:       return 8'b1101_0000;
      3:       return 8'b0110_1100;
      4:       return 8'b1001_0000;
      5:       return 8'b0000_0010;
      6:       return 8'b0000_0001;
      default: return 8'b0000_0000;
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ops(input logic [11:0] a_r, a_i, b_r, b_i);
    ar_in = a_r; ai_in = a_i; br_in = b_r; bi_in = b_i;
  endtask

  task automatic push_exp(input logic [11:0] a_r, a_i, b_r, b_i);
    exp_t e;
    logic [23:0] rr, ii, ri, ir;
    rr = 24'(a_r) * 24'(b_r);
    ii = 24'(a_i) * 24'(b_i);
    ri = 24'(a_r) * 24'(b_i);
    ir = 24'(a_i) * 24'(b_r);
    e.pr = rr - ii;
    e.pi = ri + ir;
    sb.push_back(e);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    in_valid = 1'b1;
    drive_ops(12'd9, 12'd8, 12'd7, 12'd6);
    tick;
    tick;
    checks++;
    if (ctrl !== 8'h00) begin errors++; $display("FAIL reset_ctrl: got %b want 00000000", ctrl); end
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_hs: in_ready=%b busy=%b want 1 0", in_ready, busy);
    end
    checks++;
    if ({ar, ai, br, bi} !== 48'h0) begin
      errors++; $display("FAIL reset_operands: got %h want 0", {ar, ai, br, bi});
    end
    checks++;
    if (op_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", op_count); end
    rst = 1'b0;
    in_valid = 1'b0;
    exp_count = '0;
  endtask

  task automatic test_reset_midop;
    drive_ops(12'd5, 12'd6, 12'd7, 12'd8);
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    tick;
    checks++;
    if (ctrl !== ctrl_exp(3)) begin errors++; $display("FAIL midop_s3: got %b want %b", ctrl, ctrl_exp(3)); end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checks++;
    if (ctrl !== 8'h00 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL midop_idle: ctrl=%b busy=%b in_ready=%b want 0 0 1", ctrl, busy, in_ready);
    end
    checks++;
    if ({ar, ai, br, bi} !== 48'h0) begin
      errors++; $display("FAIL midop_operands: got %h want 0", {ar, ai, br, bi});
    end
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL midop_no_valid: cycle %0d out_valid=%b want 0", k, out_valid); end
      tick;
    end
    checks++;
    if (op_count !== exp_count) begin errors++; $display("FAIL midop_count: got %0d want %0d", op_count, exp_count); end
  endtask

  task automatic test_single;
    exp_t e;
    drive_ops(12'd3, 12'd2, 12'd4, 12'd5);
    in_valid = 1'b1;
    out_ready = 1'b1;
    push_exp(12'd3, 12'd2, 12'd4, 12'd5);
    tick;
    in_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      checks++;
      if (ctrl !== ctrl_exp(k) || in_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL single_seq S%0d: ctrl=%b in_ready=%b busy=%b want %b 0 1", k, ctrl, in_ready, busy, ctrl_exp(k));
      end
      tick;
    end
    checks++;
    if (ctrl !== ctrl_exp(6)) begin errors++; $display("FAIL single_done: got %b want %b", ctrl, ctrl_exp(6)); end
    checks++;
    if (sb.size() == 0) begin
      errors++; $display("FAIL single_sb: scoreboard empty got 0 entries want 1");
    end else begin
      e = sb.pop_front();
      if (pr !== e.pr || pi !== e.pi) begin
        errors++; $display("FAIL single_result: Pr=%0d Pi=%0d want %0d %0d", pr, pi, e.pr, e.pi);
      end
    end
    tick;
    exp_count++;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL single_pulse: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
    checks++;
    if (op_count !== exp_count) begin errors++; $display("FAIL single_count: got %0d want %0d", op_count, exp_count); end
  endtask

  task automatic test_backpressure;
    exp_t e;
    logic [23:0] pr0, pi0;
    drive_ops(12'd100, 12'd7, 12'd9, 12'd300);
    in_valid = 1'b1;
    out_ready = 1'b0;
    push_exp(12'd100, 12'd7, 12'd9, 12'd300);
    tick;
    in_valid = 1'b0;
    repeat (5) tick;
    pr0 = pr;
    pi0 = pi;
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (ctrl !== 8'b0000_0001 || in_ready !== 1'b0 || pr !== pr0 || pi !== pi0) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: ctrl=%b in_ready=%b Pr=%h Pi=%h want 00000001 0 %h %h", k, ctrl, in_ready, pr, pi, pr0, pi0);
      end
      tick;
    end
    checks++;
    if (sb.size() == 0) begin
      errors++; $display("FAIL bp_sb: scoreboard empty got 0 entries want 1");
    end else begin
      e = sb.pop_front();
      if (pr !== e.pr || pi !== e.pi) begin
        errors++; $display("FAIL bp_result: Pr=%0d Pi=%0d want %0d %0d", pr, pi, e.pr, e.pi);
      end
    end
    out_ready = 1'b1;
    tick;
    exp_count++;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release: busy=%b in_ready=%b out_valid=%b want 0 1 0", busy, in_ready, out_valid);
    end
    checks++;
    if (op_count !== exp_count) begin errors++; $display("FAIL bp_count: got %0d want %0d", op_count, exp_count); end
  endtask

  task automatic test_busy_input;
    exp_t e;
    drive_ops(12'd11, 12'd22, 12'd33, 12'd44);
    in_valid = 1'b1;
    out_ready = 1'b1;
    push_exp(12'd11, 12'd22, 12'd33, 12'd44);
    tick;
    drive_ops(12'd4000, 12'd4001, 12'd4002, 12'd4003);
    for (int k = 1; k <= 6; k++) begin
      checks++;
      if (ar !== 12'd11 || ai !== 12'd22 || br !== 12'd33 || bi !== 12'd44 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL busy_hold phase %0d: ops=%0d,%0d,%0d,%0d in_ready=%b want 11,22,33,44 0", k, ar, ai, br, bi, in_ready);
      end
      if (k < 6) tick;
    end
    checks++;
    if (sb.size() == 0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL busy_done: out_valid=%b sb=%0d want 1 1", out_valid, sb.size());
    end else begin
      e = sb.pop_front();
      if (pr !== e.pr || pi !== e.pi) begin
        errors++; $display("FAIL busy_result: Pr=%0d Pi=%0d want %0d %0d", pr, pi, e.pr, e.pi);
      end
    end
    tick;
    in_valid = 1'b0;
    exp_count++;
    checks++;
    if (op_count !== exp_count || in_ready !== 1'b1) begin
      errors++; $display("FAIL busy_count: count=%0d in_ready=%b want %0d 1", op_count, in_ready, exp_count);
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    logic [11:0] ops [3][4];
    int acc;
    int n;
    ops[0] = '{12'd0, 12'd0, 12'd4095, 12'd4095};
    ops[1] = '{12'd1, 12'd4095, 12'd1, 12'd4095};
    ops[2] = '{12'd2047, 12'd1234, 12'd3000, 12'd17};
    rst = 1'b1;
    tick;
    rst = 1'b0;
    exp_count = '0;
    sb.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_ops(ops[i][0], ops[i][1], ops[i][2], ops[i][3]);
      in_valid = 1'b1;
      push_exp(ops[i][0], ops[i][1], ops[i][2], ops[i][3]);
      tick;
      in_valid = 1'b0;
      acc = cyc;
      n = 0;
      while (out_valid !== 1'b1 && n < 20) begin
        tick;
        n++;
      end
      checks++;
      if (out_valid !== 1'b1) begin
        errors++; $display("FAIL b2b_timeout op %0d: out_valid=%b want 1 within 20 cycles", i, out_valid);
      end else if (cyc - acc != 5) begin
        errors++; $display("FAIL b2b_latency op %0d: got %0d want 5", i, cyc - acc);
      end
      checks++;
      if (sb.size() == 0) begin
        errors++; $display("FAIL b2b_sb op %0d: scoreboard empty got 0 want 1", i);
      end else begin
        e = sb.pop_front();
        if (pr !== e.pr || pi !== e.pi) begin
          errors++; $display("FAIL b2b_result op %0d: Pr=%h Pi=%h want %h %h", i, pr, pi, e.pr, e.pi);
        end
      end
      tick;
      exp_count++;
    end
    checks++;
    if (op_count !== exp_count || op_count !== 16'd3) begin
      errors++; $display("FAIL b2b_count: got %0d want 3", op_count);
    end
  endtask

  initial begin
    tick;
    test_reset;
    test_reset_midop;
    test_single;
    test_backpressure;
    test_busy_input;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
